// File: rtl/im_boot_loader.sv
// im_boot_loader: fills the instruction memory from a big-endian byte stream,
// stalls the pipeline while loading, then hands the IM address bus to fetch.
// Optional macro IM_BOOT_CHECKSUM_EN adds load_sum, the mod-2^32 sum of the
// words written by the current load.
module im_boot_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] load_len,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic [AW-1:0] pc_addr,
    output logic [AW-1:0] im_addr,
    output logic          im_we,
    output logic [31:0]   im_wdata,
    output logic          cpu_stall,
    output logic          load_done,
    output logic [AW-1:0] word_cnt
`ifdef IM_BOOT_CHECKSUM_EN
    ,
    output logic [31:0]   load_sum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    // Length and count carry one extra bit so a full 1024-word load is representable.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [1:0]    byte_idx;
    logic [AW-1:0] ptr;
    logic [AW:0]   len_reg;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_inc;
    logic [AW:0]   len_in;
    logic          accept;
    logic          take_start;

    assign cnt_inc    = cnt + (AW+1)'(1);
    assign accept     = byte_valid & byte_ready;
    assign take_start = start & ((state == IDLE) | (state == DONE));
    assign word_cnt   = cnt[AW-1:0];

    // Requested length: zero means a full memory, oversize requests are clamped.
    always_comb begin
        len_in = {1'b0, load_len};
        if ((load_len == '0) || ({1'b0, load_len} > DEPTH_W)) begin
            len_in = DEPTH_W;
        end
    end

    // Next-state decode plus the combinational handshake, strobe and address mux.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        im_we      = 1'b0;
        im_addr    = ptr;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid && (byte_idx == 2'd3)) state_nxt = WRITE;
            end
            WRITE: begin
                im_we     = 1'b1;
                state_nxt = (cnt_inc == len_reg) ? DONE : LOAD;
            end
            DONE: begin
                im_addr = pc_addr;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, word assembly, pointer/count bookkeeping and registered stall/done flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            ptr       <= '0;
            len_reg   <= '0;
            cnt       <= '0;
            im_wdata  <= 32'h0;
            cpu_stall <= 1'b1;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_stall <= (state_nxt != DONE);
            load_done <= (state_nxt == DONE);
            if (take_start) begin
                len_reg  <= len_in;
                ptr      <= '0;
                cnt      <= '0;
                byte_idx <= 2'd0;
            end
            if ((state == LOAD) && accept) begin
                case (byte_idx)
                    2'd0:    im_wdata[31:24] <= byte_data;
                    2'd1:    im_wdata[23:16] <= byte_data;
                    2'd2:    im_wdata[15:8]  <= byte_data;
                    default: im_wdata[7:0]   <= byte_data;
                endcase
                byte_idx <= byte_idx + 2'd1;
            end
            if (state == WRITE) begin
                cnt      <= cnt_inc;
                ptr      <= ptr + AW'(1);
                byte_idx <= 2'd0;
            end
        end
    end

`ifdef IM_BOOT_CHECKSUM_EN
    // Running sum of every word committed to IM since the last accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_sum <= 32'h0;
        end else if (take_start) begin
            load_sum <= 32'h0;
        end else if (state == WRITE) begin
            load_sum <= load_sum + im_wdata;
        end
    end
`endif

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Loads program words into the 128-word instruction memory from an 8-bit byte stream.
- Holds the pipeline in stall while a load is in progress.
- Time-shares the IM address bus: the loader drives it while loading; the fetch-stage PC drives it once the load is done.
- Sits between the external byte source, the IM write port and the IF stage.

Parameters:
- DEPTH, 128, number of 32-bit IM words (max 1024).
- AW, 10, IM word-address width; matches address bits [11:2].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- load_len  in  AW  number of words to load; sampled on an accepted start; 0 means DEPTH.
- byte_valid  in  1  byte source has a byte on byte_data.
- byte_data  in  8  stream byte; big-endian, first byte of a word goes to bits 31:24.
- byte_ready  out  1  loader accepts a byte this cycle.
- pc_addr  in  AW  fetch word address from the IF stage (PC[11:2]).
- im_addr  out  AW  address to IM.
- im_we  out  1  IM write strobe.
- im_wdata  out  32  IM write data.
- cpu_stall  out  1  freeze PC and the IF/ID register.
- load_done  out  1  program resident; IM owned by fetch.
- word_cnt  out  AW  words written in the current or last load.

Behaviour:
- States: IDLE, LOAD, WRITE, DONE.
- Reset, asynchronous, effective immediately, also mid-load:
  - state=IDLE, byte_ready=0, im_we=0, im_wdata=0, cpu_stall=1, load_done=0, word_cnt=0.
  - Internal byte index=0, word pointer=0, length register=0.
  - Any partially assembled word is discarded.
- IDLE:
  - cpu_stall=1.
  - start=1 → LOAD next cycle. Latches the length (load_len, or DEPTH if load_len=0; values above DEPTH are clamped to DEPTH).
  - Clears the word pointer, word_cnt and byte index.
- LOAD:
  - byte_ready=1.
  - A byte is accepted only when byte_valid & byte_ready. It is shifted into im_wdata at lane 3-byte_index.
  - The 4th accepted byte → WRITE next cycle; byte_ready=0 in WRITE.
  - No byte accepted → state holds; no timeout.
- WRITE (exactly one cycle):
  - im_we=1, im_addr=word pointer, im_wdata=assembled word.
  - Next edge: word_cnt and pointer increment. If the new word_cnt equals the length → DONE, else → LOAD with byte index=0.
- DONE:
  - cpu_stall=0, load_done=1, byte_ready=0, im_we=0.
  - start=1 → LOAD with a fresh length, pointer and word_cnt=0. cpu_stall=1 and load_done=0 from the next cycle on.
- im_addr is combinational:
  - pc_addr when state==DONE.
  - word pointer in all other states.
  - Fetch latency is unchanged: IM read stays combinational.
- start is ignored in LOAD and WRITE; the load continues uninterrupted.
- cpu_stall and load_done are registered, decoded from the next state; they change on the edge that enters or leaves DONE.
- Pointer arithmetic is AW bits; it cannot wrap because length ≤ DEPTH.
- Bytes offered outside LOAD are not consumed; the source must hold byte_valid.

Optional Feature:
- Macro IM_BOOT_CHECKSUM_EN.
- With the macro:
  - Adds output load_sum[31:0], the modulo-2^32 sum of all words written in the current load.
  - Cleared to 0 on reset and on an accepted start; updated on each WRITE cycle.
  - Stable in DONE.
- Without the macro: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with load_len=2, stream 8C,01,00,04,20,02,00,05 with byte_valid always 1 → im_we pulses twice:
  - addr 0 data 8C010004, then addr 1 data 20020005.
  - Ends in DONE: load_done=1, cpu_stall=0, word_cnt=2.
  - With IM_BOOT_CHECKSUM_EN, load_sum=AC030009.
- In DONE, drive pc_addr=0x005 → im_addr=0x005 the same cycle; im_we stays 0.
- Gapped stream (byte_valid low 3 cycles between bytes) → same writes and final state as the no-gap case; word content is unaffected by the gaps.
- start with load_len=0, stream 512 bytes → 128 writes at addr 0..127; DONE with word_cnt=128.
- rstn low after 6 bytes of a 3-word load → immediately IDLE, cpu_stall=1, word_cnt=0. A new start plus 12 bytes rewrites addr 0..2 from the first byte.
- start pulsed during LOAD → ignored, length unchanged. A start in DONE → cpu_stall=1 and load_done=0 on the next edge, then a fresh load at addr 0.
